program_load_ctrl: RTL and testbench
====================================

Name: program_load_ctrl

Overview:
- Sequences the 64x16 instruction memory in two modes.
- LOAD mode: assembles 16-bit instruction words from three debounced button presses sampling 8-bit switches, then issues one write per word.
- RUN mode: releases the CPU from reset and services its fetch requests against the memory read port with 1-cycle latency.
- Sits between board I/O (switches, buttons), the instruction memory and the CPU fetch stage.

Parameters:
- ADDR_W, 6, memory address width.
- DEPTH, 64, number of instruction words; must be at most 2**ADDR_W.
- DEBOUNCE_CYCLES, 16, consecutive stable samples required to accept a button level change.
- HALT_WORD, 16'h0000, instruction returned for a fetch at or beyond the loaded program length.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- instruction  in  8  switch inputs; phases 0 and 1 use [5:0], phase 2 uses [3:0].
- button  in  1  raw, asynchronous load push-button.
- run  in  1  level, synchronised internally; 1 = RUN, 0 = LOAD.
- fetch_req  in  1  CPU fetch request, RUN only.
- fetch_addr  in  ADDR_W  CPU fetch address.
- mem_we  out  1  single-cycle write strobe to memory.
- mem_waddr  out  ADDR_W  write address.
- mem_wdata  out  16  write data.
- mem_raddr  out  ADDR_W  read address to the synchronous memory (data valid the following cycle).
- mem_rdata  in  16  read data from memory.
- fetch_valid  out  1  fetch_instr valid, one cycle after an accepted fetch_req.
- fetch_instr  out  16  fetched instruction.
- cpu_reset_n  out  1  active-low CPU reset; low in LOAD, high in RUN.
- prog_len  out  ADDR_W+1  number of words written since entering LOAD.
- load_phase  out  2  current assembly phase, 0 to 2, for display.
- full  out  1  prog_len == DEPTH.

Behaviour:
- Reset (reset=0, asynchronous) puts all outputs at 0:
  - mode=LOAD, phase=0, prog_len=0, debouncer state cleared, cpu_reset_n=0.
  - Reset mid-word discards the partial word. Reset during RUN returns to LOAD.
- Button path:
  - 2-flop synchroniser, then a stability counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A 0->1 debounced transition produces a 1-cycle press pulse. Glitches shorter than DEBOUNCE_CYCLES produce nothing.
- run path: 2-flop synchronised. Mode changes 2 cycles after the raw edge.
- LOAD, on each press pulse:
  - Phase 0: word[15:10] = instruction[5:0], word[9:0] = 0, then phase 1.
  - Phase 1: word[9:4] = instruction[5:0], then phase 2.
  - Phase 2: word[3:0] = instruction[3:0].
    - In the same cycle drive mem_we=1, mem_waddr=prog_len[ADDR_W-1:0], mem_wdata = completed word.
    - Next cycle prog_len+1, phase 0.
  - mem_we is high for exactly 1 cycle per completed word.
- Full: when full=1, press pulses are ignored. Phase stays 0, no write, no wrap to address 0.
- LOAD -> RUN on synchronised run=1:
  - Any partial word (phase != 0) is discarded and phase goes to 0.
  - cpu_reset_n goes to 1 in the first RUN cycle.
  - prog_len is frozen.
- RUN -> LOAD on run=0:
  - cpu_reset_n=0 in the same cycle, prog_len cleared to 0, phase 0.
  - Any in-flight fetch response is suppressed (fetch_valid=0).
- Fetch (RUN only):
  - fetch_req=1 in cycle N drives mem_raddr=fetch_addr combinationally in cycle N.
  - In cycle N+1: fetch_valid=1 and fetch_instr = mem_rdata if fetch_addr < prog_len, else HALT_WORD (comparison registered in cycle N).
  - Back-to-back requests give one response per cycle.
  - fetch_req in LOAD is ignored: fetch_valid=0 and fetch_instr holds 0.
- Button presses in RUN are ignored and do not alter phase.
- The write and read ports are never active in the same mode, so there is no port conflict.

Test Plan:
- DEBOUNCE_CYCLES=4; raw button pulse 2 cycles wide, then 3 cycles wide -> no press pulse, load_phase stays 0, mem_we never asserted.
- LOAD, three clean presses with instruction = 8'h01, 8'h00, 8'h01 -> one mem_we pulse with mem_waddr=0, mem_wdata=16'h0401; then prog_len=1, load_phase=0.
- Load 2 words, make 1 extra press (phase=1), raise run -> cpu_reset_n rises 2 cycles after run, prog_len=2, no third write, load_phase=0.
- RUN, fetch_req with addresses 0, 1, 2 on consecutive cycles -> fetch_valid high for 3 consecutive cycles; instructions word0, word1, HALT_WORD (16'h0000).
- Load 64 words, then 3 more presses -> full=1, prog_len=64, no additional mem_we, no write to address 0.
- RUN with fetch outstanding, drop run -> fetch_valid=0, cpu_reset_n=0, prog_len=0. Then assert reset=0 mid-phase-1 in LOAD -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/program_load_ctrl.sv
// program_load_ctrl: sequences a 64x16 instruction memory in two modes.
//   LOAD: each debounced button press samples the switches into one of three
//         fields of a 16-bit word; the third press writes the word at prog_len.
//   RUN : CPU is released from reset; fetch requests go straight to the memory
//         read port and the answer is returned one cycle later.
// Ports:
//   clk, reset (async, active low)
//   instruction[7:0], button, run      board switches / push-button / mode level
//   fetch_req, fetch_addr              CPU fetch request
//   mem_we, mem_waddr, mem_wdata       memory write port
//   mem_raddr, mem_rdata               synchronous memory read port
//   fetch_valid, fetch_instr           fetch response
//   cpu_reset_n, prog_len, load_phase, full   status
module program_load_ctrl #(
  parameter int          ADDR_W          = 6,
  parameter int          DEPTH           = 64,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [15:0] HALT_WORD       = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        instruction,
  input  logic              button,
  input  logic              run,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [15:0]       mem_rdata,
  output logic              fetch_valid,
  output logic [15:0]       fetch_instr,
  output logic              cpu_reset_n,
  output logic [ADDR_W:0]   prog_len,
  output logic [1:0]        load_phase,
  output logic              full
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} mode_e;

  // ---------------- button synchroniser + debouncer ----------------
  logic             btn_s1_q, btn_s2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;

  // cnt counts consecutive samples that differ from the accepted level; the
  // level flips on the DEBOUNCE_CYCLES-th such sample, any equal sample restarts.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    press = 1'b0;
    if (btn_s2_q != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = btn_s2_q;
        press = btn_s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // ---------------- mode FSM ----------------
  // The second run synchroniser flop is the mode register itself, so the mode
  // follows the raw level two cycles later.
  logic  run_s1_q;
  mode_e state_q, state_d;

  assign state_d = run_s1_q ? S_RUN : S_LOAD;

  // ---------------- load datapath ----------------
  logic [1:0]      phase_q, phase_d;
  logic [11:0]     word_q, word_d;     // word bits [15:4]
  logic [ADDR_W:0] len_q, len_d;
  logic            we;

  assign full = (len_q == (ADDR_W + 1)'(DEPTH));

  always_comb begin
    phase_d = phase_q;
    word_d  = word_q;
    len_d   = len_q;
    we      = 1'b0;
    if (state_q == S_RUN) begin
      if (state_d == S_LOAD) len_d = '0;
    end else if (press && !full) begin
      case (phase_q)
        2'd0: begin
          word_d  = {instruction[5:0], 6'b0};
          phase_d = 2'd1;
        end
        2'd1: begin
          word_d[5:0] = instruction[5:0];
          phase_d     = 2'd2;
        end
        2'd2: begin
          we      = 1'b1;
          len_d   = len_q + 1'b1;
          phase_d = 2'd0;
        end
        default: phase_d = 2'd0;
      endcase
    end
    // Partial words never survive into RUN.
    if (state_d == S_RUN) phase_d = 2'd0;
  end

  // ---------------- fetch path ----------------
  logic fv_q, fv_d, hit_q, hit_d;

  // A response is only produced if RUN holds in both request and reply cycles,
  // which drops anything in flight when leaving RUN.
  assign fv_d  = fetch_req && (state_q == S_RUN) && (state_d == S_RUN);
  assign hit_d = ({1'b0, fetch_addr} < len_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      deb_q    <= 1'b0;
      cnt_q    <= '0;
      run_s1_q <= 1'b0;
      state_q  <= S_LOAD;
      phase_q  <= 2'd0;
      word_q   <= '0;
      len_q    <= '0;
      fv_q     <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      btn_s1_q <= button;
      btn_s2_q <= btn_s1_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      run_s1_q <= run;
      state_q  <= state_d;
      phase_q  <= phase_d;
      word_q   <= word_d;
      len_q    <= len_d;
      fv_q     <= fv_d;
      hit_q    <= hit_d;
    end
  end

  // ---------------- outputs ----------------
  assign mem_we      = we;
  assign mem_waddr   = we ? len_q[ADDR_W-1:0] : '0;
  assign mem_wdata   = we ? {word_q, instruction[3:0]} : '0;
  assign mem_raddr   = (state_q == S_RUN && fetch_req) ? fetch_addr : '0;
  assign fetch_valid = fv_q;
  assign fetch_instr = fv_q ? (hit_q ? mem_rdata : HALT_WORD) : '0;
  assign cpu_reset_n = (state_q == S_RUN);
  assign prog_len    = len_q;
  assign load_phase  = phase_q;

  logic unused_instr_hi;
  assign unused_instr_hi = ^instruction[7:6];

endmodule

// File: tb/tb_program_load_ctrl.sv
module tb_program_load_ctrl;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset, button, run, fetch_req;
  logic [7:0]  instruction;
  logic [5:0]  fetch_addr;
  logic        mem_we, fetch_valid, cpu_reset_n, full;
  logic [5:0]  mem_waddr, mem_raddr;
  logic [15:0] mem_wdata, mem_rdata, fetch_instr;
  logic [6:0]  prog_len;
  logic [1:0]  load_phase;

  program_load_ctrl #(.ADDR_W(6), .DEPTH(64), .DEBOUNCE_CYCLES(DEB), .HALT_WORD(16'h0000)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .button(button), .run(run),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .cpu_reset_n(cpu_reset_n),
    .prog_len(prog_len), .load_phase(load_phase), .full(full));

  always #5 clk = ~clk;

  // Synchronous instruction memory seen by the DUT.
  logic [15:0] ram [0:63];
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    mem_rdata <= ram[mem_raddr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [21:0] wq[$];       // expected writes {addr, data}
  logic [15:0] fq[$];       // expected fetch responses
  logic [15:0] prog [0:63]; // words the program should contain
  int          mlen = 0;
  int          mphase = 0;
  logic [5:0]  m_hi, m_mid;
  logic        run_d1 = 1'b0, run_d2 = 1'b0; // run level one and two cycles back

  // One clock; afterwards inputs belong to the new cycle.
  task automatic tick();
    @(posedge clk); #1;
    run_d2 = run_d1;
    run_d1 = run;
  endtask

  // A clean press: the model records its effect before the button rises so the
  // write expectation is already queued when mem_we appears.
  task automatic press(input logic [7:0] v);
    if (mlen < 64) begin
      case (mphase)
        0: begin m_hi = v[5:0]; mphase = 1; end
        1: begin m_mid = v[5:0]; mphase = 2; end
        default: begin
          prog[mlen] = {m_hi, m_mid, v[3:0]};
          wq.push_back({6'(mlen), m_hi, m_mid, v[3:0]});
          mlen++;
          mphase = 0;
        end
      endcase
    end
    instruction = v;
    button = 1'b1;
    repeat (DEB + 4) tick();
    button = 1'b0;
    repeat (DEB + 4) tick();
    instruction = 8'($urandom);
  endtask

  task automatic check_load_state(input string tag);
    chk({tag, "_phase"}, 64'(load_phase), 64'(mphase));
    chk({tag, "_len"},   64'(prog_len),   64'(mlen));
    chk({tag, "_full"},  64'(full),       64'(mlen == 64));
  endtask

  // A request is answered iff the DUT is in RUN in both the request cycle and
  // the following one; mode lags the raw run level by two cycles.
  task automatic fetch(input logic req, input logic [5:0] a);
    fetch_req  = req;
    fetch_addr = a;
    if (req && run_d2 && run_d1)
      fq.push_back((int'(a) < mlen) ? prog[a] : 16'h0000);
    tick();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (mem_we) begin
        if (wq.size() == 0) chk("unexpected_write", {mem_waddr, mem_wdata}, 64'h0);
        else begin
          logic [21:0] e;
          e = wq.pop_front();
          chk("write_addr", 64'(mem_waddr), 64'(e[21:16]));
          chk("write_data", 64'(mem_wdata), 64'(e[15:0]));
        end
      end
      if (fetch_valid) begin
        if (fq.size() == 0) chk("unexpected_fetch", 64'(fetch_instr), 64'hdead);
        else chk("fetch_instr", 64'(fetch_instr), 64'(fq.pop_front()));
      end else if (!run_d2) begin
        chk("fetch_instr_idle", 64'(fetch_instr), 64'h0);
      end
      chk("cpu_reset_n", 64'(cpu_reset_n), 64'(run_d2));
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
    reset = 1'b0; button = 1'b0; run = 1'b0; fetch_req = 1'b0;
    fetch_addr = '0; instruction = 8'h00;
    repeat (3) tick();
    chk("reset_outputs", {mem_we, mem_waddr, mem_wdata, mem_raddr, fetch_valid, fetch_instr,
                          cpu_reset_n, prog_len, load_phase, full}, 64'h0);
    reset = 1'b1;
    repeat (2) tick();

    // Glitches shorter than the debounce window.
    button = 1'b1; repeat (2) tick();
    button = 1'b0; repeat (6) tick();
    button = 1'b1; repeat (3) tick();
    button = 1'b0; repeat (8) tick();
    check_load_state("glitch");

    // Directed first word 0x0401.
    press(8'h01); check_load_state("p0");
    press(8'h00); check_load_state("p1");
    press(8'h01); check_load_state("w0");
    chk("word0_model", 64'(prog[0]), 64'h0401);

    // Second word plus a dangling partial, then enter RUN.
    for (int i = 0; i < 3; i++) press(8'($urandom));
    press(8'($urandom));
    check_load_state("partial");
    run = 1'b1;
    tick(); chk("cpu_rst_1cyc", 64'(cpu_reset_n), 64'h0);
    tick(); chk("cpu_rst_2cyc", 64'(cpu_reset_n), 64'h1);
    mphase = 0;
    check_load_state("run_entry");

    // Back-to-back fetches 0,1,2 then random traffic.
    fetch(1'b1, 6'd0); fetch(1'b1, 6'd1); fetch(1'b1, 6'd2);
    for (int i = 0; i < 30; i++) fetch(1'($urandom), 6'($urandom_range(0, 5)));
    fetch(1'b0, 6'd0);

    // Presses in RUN are ignored.
    instruction = 8'h3f; button = 1'b1; repeat (DEB + 4) tick();
    button = 1'b0; repeat (DEB + 4) tick();
    check_load_state("run_press");

    // Drop run with fetches in flight.
    fetch(1'b1, 6'd0);
    run = 1'b0;
    for (int i = 0; i < 4; i++) fetch(1'b1, 6'($urandom));
    fetch(1'b0, 6'd0);
    mlen = 0; mphase = 0;
    check_load_state("run_exit");
    chk("exit_cpu_rst", 64'(cpu_reset_n), 64'h0);

    // Fill the memory, then try to overflow.
    for (int i = 0; i < 64 * 3; i++) press(8'($urandom));
    check_load_state("full");
    for (int i = 0; i < 3; i++) press(8'($urandom));
    check_load_state("over_full");

    // Read the whole program back.
    run = 1'b1; tick(); tick();
    for (int a = 0; a < 64; a++) fetch(1'b1, 6'(a));
    for (int i = 0; i < 20; i++) fetch(1'($urandom), 6'($urandom));
    fetch(1'b0, 6'd0);
    run = 1'b0;
    repeat (3) fetch(1'b0, 6'd0);
    mlen = 0; mphase = 0;
    check_load_state("second_exit");

    // Asynchronous reset while in phase 1.
    press(8'($urandom));
    check_load_state("pre_reset");
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("async_reset", {mem_we, mem_waddr, mem_wdata, mem_raddr, fetch_valid, fetch_instr,
                        cpu_reset_n, prog_len, load_phase, full}, 64'h0);
    mlen = 0; mphase = 0; run_d1 = 1'b0; run_d2 = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) press(8'($urandom));
    check_load_state("after_reset");

    repeat (4) tick();
    chk("writes_drained", 64'(wq.size()), 64'h0);
    chk("fetches_drained", 64'(fq.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
